// File: rtl/fft_pkg.sv
// Shared types and helpers for the radix-4 FFT output mixer sequencer.
package fft_pkg;

    localparam int RADIX = 4;

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    function automatic int digitsOf(input int addr);
        return addr / 2 + 1;
    endfunction

    // Sum of base-4 digits, kept mod 4 by the 2-bit accumulator wrap.
    function automatic logic [1:0] digitSumMod4(input logic [31:0] v);
        logic [1:0] acc;
        acc = 2'd0;
        for (int i = 0; i < 16; i++) begin
            acc = acc + v[2*i +: 2];
        end
        return acc;
    endfunction

endpackage

// File: rtl/fft_mix_addr_gen.sv
// Combinational per-bank write address generator for one butterfly.
module fft_mix_addr_gen
    import fft_pkg::*;
#(
    parameter int ADDR      = 4,
    parameter int STAGE_BIT = 3
) (
    input  logic [ADDR-1:0]      j,
    input  logic [STAGE_BIT-1:0] s,
    input  logic [1:0]           sel,
    output logic [ADDR-1:0]      addr0,
    output logic [ADDR-1:0]      addr1,
    output logic [ADDR-1:0]      addr2,
    output logic [ADDR-1:0]      addr3
);

    localparam int IW = ADDR + 2;

    logic [IW-1:0]      jx;
    logic [STAGE_BIT:0] sh;
    logic [STAGE_BIT:0] shHi;
    logic [IW-1:0]      hi;
    logic [IW-1:0]      lo;
    logic [IW-1:0]      idx [RADIX];
    logic [ADDR-1:0]    addrM [RADIX];

    always_comb begin
        jx   = IW'(j);
        sh   = {s, 1'b0};
        shHi = sh + (STAGE_BIT+1)'(2);
        hi   = (jx >> sh) << shHi;
        lo   = jx & ((IW'(1) << sh) - IW'(1));
        for (int m = 0; m < RADIX; m++) begin
            idx[m]   = hi | (IW'(m) << sh) | lo;
            addrM[m] = idx[m][IW-1:2];
        end
    end

    // Bank b receives output m = (b - sel) mod 4.
    assign addr0 = addrM[2'd0 - sel];
    assign addr1 = addrM[2'd1 - sel];
    assign addr2 = addrM[2'd2 - sel];
    assign addr3 = addrM[2'd3 - sel];

endmodule

// File: rtl/fft_output_mix_ctrl.sv
// Radix-4 FFT output rotation mixer sequencer.
// Optional sticky error flag oERR with FFT_OUTPUT_MIX_CTRL_ERR_EN.
module fft_output_mix_ctrl
    import fft_pkg::*;
#(
    parameter int ADDR      = 4,
    parameter int STAGE_BIT = 3
) (
    input  logic                 iCLK,
    input  logic                 iRESET,
    input  logic                 iSTART,
    input  logic [STAGE_BIT-1:0] iSTAGE,
    input  logic                 iVALID,
    output logic [1:0]           oSEL,
    output logic                 oWR_EN,
    output logic [ADDR-1:0]      oWR_ADDR0,
    output logic [ADDR-1:0]      oWR_ADDR1,
    output logic [ADDR-1:0]      oWR_ADDR2,
    output logic [ADDR-1:0]      oWR_ADDR3,
    output logic                 oBUSY,
`ifdef FFT_OUTPUT_MIX_CTRL_ERR_EN
    output logic                 oERR,
`endif
    output logic                 oDONE
);

    localparam int            LAST_STAGE = ADDR / 2;
    localparam logic [ADDR-1:0] J_MAX    = '1;

    state_e               state;
    state_e               nextState;
    logic [ADDR-1:0]      j;
    logic [STAGE_BIT-1:0] s;
    logic                 accept;
    logic                 fire;
    logic                 last;
    logic [ADDR-1:0]      genA0;
    logic [ADDR-1:0]      genA1;
    logic [ADDR-1:0]      genA2;
    logic [ADDR-1:0]      genA3;

    assign accept = (state == IDLE) && iSTART
                  && (int'(iSTAGE) <= LAST_STAGE);
    assign fire   = (state == RUN) && iVALID;
    assign last   = fire && (j == J_MAX);
    assign oBUSY  = (state == RUN);
    assign oSEL   = oBUSY ? digitSumMod4(32'(j)) : 2'd0;

    fft_mix_addr_gen #(
        .ADDR      (ADDR),
        .STAGE_BIT (STAGE_BIT)
    ) uAddrGen (
        .j     (j),
        .s     (s),
        .sel   (oSEL),
        .addr0 (genA0),
        .addr1 (genA1),
        .addr2 (genA2),
        .addr3 (genA3)
    );

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) state <= IDLE;
        else         state <= nextState;
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: if (accept) nextState = RUN;
            RUN:  if (last)   nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            j         <= '0;
            s         <= '0;
            oWR_EN    <= 1'b0;
            oDONE     <= 1'b0;
            oWR_ADDR0 <= '0;
            oWR_ADDR1 <= '0;
            oWR_ADDR2 <= '0;
            oWR_ADDR3 <= '0;
        end else begin
            if (accept) begin
                j <= '0;
                s <= iSTAGE;
            end else if (fire) begin
                j <= j + 1'b1;
            end
            oWR_EN <= fire;
            oDONE  <= last;
            // Addresses hold between writes.
            if (fire) begin
                oWR_ADDR0 <= genA0;
                oWR_ADDR1 <= genA1;
                oWR_ADDR2 <= genA2;
                oWR_ADDR3 <= genA3;
            end
        end
    end

`ifdef FFT_OUTPUT_MIX_CTRL_ERR_EN
    logic errEvent;
    assign errEvent = (state == IDLE) && ((iSTART && !accept) || iVALID);

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET)       oERR <= 1'b0;
        else if (accept)   oERR <= 1'b0;
        else if (errEvent) oERR <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_fft_output_mix_ctrl.sv
// Randomized bench for fft_output_mix_ctrl against a spec-level model.
module tb_fft_output_mix_ctrl;

    localparam int ADDR = 4;
    localparam int SB   = 3;
    localparam int NBF  = 1 << ADDR;

    logic          iCLK = 1'b0;
    logic          iRESET;
    logic          iSTART;
    logic [SB-1:0] iSTAGE;
    logic          iVALID;
    logic [1:0]    oSEL;
    logic          oWR_EN;
    logic [ADDR-1:0] oWR_ADDR0, oWR_ADDR1, oWR_ADDR2, oWR_ADDR3;
    logic          oBUSY;
    logic          oDONE;
`ifdef FFT_OUTPUT_MIX_CTRL_ERR_EN
    logic          oERR;
`endif

    fft_output_mix_ctrl #(.ADDR(ADDR), .STAGE_BIT(SB)) dut (
        .iCLK      (iCLK),
        .iRESET    (iRESET),
        .iSTART    (iSTART),
        .iSTAGE    (iSTAGE),
        .iVALID    (iVALID),
        .oSEL      (oSEL),
        .oWR_EN    (oWR_EN),
        .oWR_ADDR0 (oWR_ADDR0),
        .oWR_ADDR1 (oWR_ADDR1),
        .oWR_ADDR2 (oWR_ADDR2),
        .oWR_ADDR3 (oWR_ADDR3),
        .oBUSY     (oBUSY),
`ifdef FFT_OUTPUT_MIX_CTRL_ERR_EN
        .oERR      (oERR),
`endif
        .oDONE     (oDONE)
    );

    always #5 iCLK = ~iCLK;

    int nChecks = 0;
    int nFails  = 0;

    int mBusy, mJ, mS, mWr, mDone, mErr;
    int mAddr [4];
    int mLastJ, mLastS;
    int dutWrCount;

    task automatic chk(input string tag, input int obs, input int exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int dsum(input int v);
        int acc = 0;
        while (v > 0) begin
            acc += v % 4;
            v /= 4;
        end
        return acc % 4;
    endfunction

    function automatic int bankAddr(input int jj, input int ss, input int b);
        int m, idx;
        m   = (b - dsum(jj) + 4) % 4;
        idx = ((jj >> (2*ss)) << (2*ss + 2)) | (m << (2*ss))
            | (jj & ((1 << (2*ss)) - 1));
        return idx >> 2;
    endfunction

    // Hand-computed addresses for the butterflies the test plan names.
    function automatic int golden(input int ss, input int jj, input int b);
        int t [4];
        if (ss == 0 && jj == 5)       t = '{5, 5, 5, 5};
        else if (ss == 1 && jj == 5)  t = '{6, 7, 4, 5};
        else if (ss == 2 && jj == 5)  t = '{9, 13, 1, 5};
        else if (ss == 2 && jj == 15) t = '{11, 15, 3, 7};
        else return -1;
        return t[b];
    endfunction

    task automatic modelReset();
        mBusy = 0; mJ = 0; mS = 0; mWr = 0; mDone = 0; mErr = 0;
        mLastJ = -1; mLastS = -1;
        for (int b = 0; b < 4; b++) mAddr[b] = 0;
    endtask

    task automatic checkOutputs();
        int dut [4];
        dut = '{int'(oWR_ADDR0), int'(oWR_ADDR1),
                int'(oWR_ADDR2), int'(oWR_ADDR3)};
        chk("sel", int'(oSEL), mBusy ? dsum(mJ) : 0);
        chk("busy", int'(oBUSY), mBusy);
        chk("wr_en", int'(oWR_EN), mWr);
        chk("done", int'(oDONE), mDone);
        for (int b = 0; b < 4; b++) chk($sformatf("addr%0d", b), dut[b], mAddr[b]);
`ifdef FFT_OUTPUT_MIX_CTRL_ERR_EN
        chk("err", int'(oERR), mErr);
`endif
        if (mBusy && (mJ == 5 || mJ == 15)) chk("sel_j5_j15", int'(oSEL), 2);
        if (mWr) begin
            for (int b = 0; b < 4; b++)
                if (golden(mLastS, mLastJ, b) >= 0)
                    chk($sformatf("gold_s%0d_j%0d_b%0d", mLastS, mLastJ, b),
                        dut[b], golden(mLastS, mLastJ, b));
        end
        if (oWR_EN === 1'b1) dutWrCount++;
        if (mDone) chk("wr_count", dutWrCount, NBF);
    endtask

    task automatic cycle(input bit st, input int stg, input bit v);
        checkOutputs();
        iSTART = st;
        iSTAGE = SB'(stg);
        iVALID = v;
        mWr = 0;
        mDone = 0;
        if (!mBusy) begin
            if (st && stg <= ADDR/2) begin
                mBusy = 1; mJ = 0; mS = stg; mErr = 0; dutWrCount = 0;
            end else if (st || v) begin
                mErr = 1;
            end
        end else if (v) begin
            mWr = 1;
            for (int b = 0; b < 4; b++) mAddr[b] = bankAddr(mJ, mS, b);
            mLastJ = mJ;
            mLastS = mS;
            if (mJ == NBF - 1) begin
                mDone = 1;
                mBusy = 0;
            end
            mJ = (mJ + 1) % NBF;
        end
        @(posedge iCLK);
        @(negedge iCLK);
    endtask

    task automatic runPass(input int stg, input int stallPct, input bit poke);
        int n = 0;
        cycle(1'b1, stg, 1'b0);
        while (mBusy && n < 400) begin
            cycle(poke && ($urandom % 6 == 0), $urandom_range(0, 7),
                  ($urandom % 100) >= stallPct);
            n++;
        end
        chk("pass_timeout", mBusy, 0);
    endtask

    initial begin
        iRESET = 1'b0;
        iSTART = 1'b0;
        iSTAGE = '0;
        iVALID = 1'b0;
        dutWrCount = 0;
        modelReset();
        @(negedge iCLK);
        @(negedge iCLK);
        checkOutputs();
        iRESET = 1'b1;

        for (int i = 0; i < 4; i++) cycle(1'b0, 0, 1'b1);
        cycle(1'b0, 0, 1'b0);

        for (int s = 0; s <= ADDR/2; s++) runPass(s, 0, 1'b0);
        cycle(1'b0, 0, 1'b0);

        for (int k = 0; k < 6; k++) runPass($urandom_range(0, 2), 40, 1'b1);

        runPass(2, 0, 1'b0);
        runPass(1, 30, 1'b0);
        cycle(1'b0, 0, 1'b0);

        cycle(1'b1, 3, 1'b0);
        cycle(1'b0, 0, 1'b0);
        cycle(1'b1, 7, 1'b0);
        cycle(1'b0, 0, 1'b0);

        cycle(1'b1, 1, 1'b0);
        while (mBusy && mJ < 7) cycle(1'b0, 0, 1'b1);
        chk("abort_at_j7", mJ, 7);
        iVALID = 1'b1;
        iRESET = 1'b0;
        modelReset();
        #1;
        checkOutputs();
        @(negedge iCLK);
        checkOutputs();
        iRESET = 1'b1;
        iVALID = 1'b0;
        cycle(1'b0, 0, 1'b0);

        runPass(0, 20, 1'b0);
        cycle(1'b0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nChecks, nFails);
        $finish;
    end

endmodule
